stack_evaluator: RTL
====================

Name: stack_evaluator

Overview:
- Downstream stage of the sliding-row shifter in the stacker game.
- When the player presses stop, it captures the halted row and intersects it with the row stacked beneath.
- It commits the trimmed overlap into the board memory and advances the level.
- It hands the trimmed row back as the seed for the next sliding row, and flags win or loss for the display/top-level FSM.

Parameters:
- WIDTH, 8, columns per row; must match the shifter's row width.
- HEIGHT, 8, rows on the board; reaching this level wins.
- INIT_BLOCK, 8'b11100000, seed row after reset or restart; WIDTH bits wide.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- stopBtn  input  1  debounced stop button level; synchronous to clk.
- restart  input  1  synchronous one-cycle request to start a new game.
- blockLoc  input  WIDTH  current row position from the shifter.
- nextBlock  output  WIDTH  seed row for the shifter's next load.
- loadNext  output  1  one-cycle strobe: shifter must reload from nextBlock.
- level  output  $clog2(HEIGHT+1)  number of committed rows, 0..HEIGHT.
- boardFlat  output  WIDTH*HEIGHT  board image; row r occupies bits [r*WIDTH +: WIDTH].
- busy  output  1  high in S_CAPT, S_EVAL and S_COMMIT.
- gameOver  output  1  sticky loss flag.
- gameWon  output  1  sticky win flag.

Behaviour:
- Reset (async, rst=1) sets:
  - board = 0, level = 0, nextBlock = INIT_BLOCK.
  - loadNext = 0, gameOver = 0, gameWon = 0.
  - stopBtn edge register = 0, state = S_IDLE.
- Edge detect: stopRise = stopBtn & ~stopPrev. stopPrev is registered every cycle. Holding the button yields exactly one event.
- States and transitions:
  - S_IDLE: on stopRise, latch placed <= blockLoc and go to S_CAPT.
  - S_CAPT: one cycle; overlapReg <= (level==0) ? placed : (placed & board[level-1]); go to S_EVAL.
  - S_EVAL:
    - If overlapReg == 0: gameOver <= 1, go to S_LOSE.
    - Otherwise go to S_COMMIT.
  - S_COMMIT:
    - board[level] <= overlapReg; level <= level+1; nextBlock <= overlapReg.
    - If level == HEIGHT-1: gameWon <= 1, go to S_WIN, and loadNext stays 0.
    - Otherwise loadNext <= 1 for exactly one cycle, go to S_IDLE.
  - S_WIN / S_LOSE: terminal. Ignore stopBtn; hold all outputs.
- Latency: stopRise sampled at edge E. Board, level and nextBlock are updated at E+3. loadNext is high during the cycle after E+3.
- Level 0: the placed row is accepted unchanged. A zero row (shifter slid off the edge) still loses.
- Stop events are ignored while busy or in a terminal state. No queuing.
- restart:
  - Accepted in any state. Takes priority over stopRise the same cycle.
  - Clears board, level, gameOver and gameWon; nextBlock <= INIT_BLOCK; state <= S_IDLE.
  - loadNext <= 1 for one cycle.
  - restart arriving mid-evaluation aborts it; no partial board write.
- Width rules:
  - Overlap is a bitwise AND; width never grows.
  - level never exceeds HEIGHT and does not wrap.
- Async reset in any state returns to the reset values immediately. No loadNext strobe is produced on reset.

Decomposition:
- Shared package stacker_pkg holds:
  - WIDTH and HEIGHT defaults, and INIT_BLOCK.
  - The state encoding: S_IDLE, S_CAPT, S_EVAL, S_COMMIT, S_WIN, S_LOSE.
  - The LVL_W = $clog2(HEIGHT+1) constant, shared with the shifter and display.
- Sub-module stack_board: a HEIGHT x WIDTH register file with one write port (wr_en, wr_row, wr_data), an async read of row (level-1), synchronous clear, and the flattened output.
- The FSM and edge detect stay in stack_evaluator.

Test Plan:
- Reset, then stopBtn high 1 cycle with blockLoc=8'b11100000 -> at E+3: level=1, board row0=8'b11100000, nextBlock=8'b11100000; loadNext pulses once.
- Then stop with blockLoc=8'b01110000 -> level=2, row1=8'b01100000, nextBlock=8'b01100000.
- Then stop with blockLoc=8'b00011000 -> overlap 0, gameOver=1 at E+2, level stays 2, no loadNext. A further stopBtn edge changes nothing.
- Hold stopBtn high 10 cycles with blockLoc=8'b11100000 from reset -> exactly one commit, level=1. A second rising edge during busy is ignored.
- Eight aligned placements of 8'b00011000 -> level=8, gameWon=1 and loadNext absent on the final commit. restart -> board=0, level=0, nextBlock=8'b11100000, one loadNext pulse.
- Assert rst in S_EVAL (one cycle after the stop edge) -> all outputs return to reset values asynchronously. Row level is not written; the next stop commits to row0.

Source files
------------

// File: rtl/stacker_pkg.sv
// ============================================================================
//  Module      : stacker_pkg
//  Description : Shared constants and state encoding for the stacker game:
//                default row width, board height, seed row, level-counter
//                width and the evaluator state machine encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stacker_pkg;

    localparam int                    DEF_WIDTH      = 8;
    localparam int                    DEF_HEIGHT     = 8;
    localparam logic [DEF_WIDTH-1:0]  DEF_INIT_BLOCK = 8'b11100000;

    // Level counter must represent 0..HEIGHT inclusive.
    localparam int                    LVL_W          = $clog2(DEF_HEIGHT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CAPT   = 3'd1,
        S_EVAL   = 3'd2,
        S_COMMIT = 3'd3,
        S_WIN    = 3'd4,
        S_LOSE   = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/stack_board.sv
// ============================================================================
//  Module      : stack_board
//  Description : HEIGHT x WIDTH register file holding the stacked rows.
//                One synchronous write port, one asynchronous read port,
//                synchronous clear (dominates the write) and a flattened
//                image of the whole board.
//  Ports       : clk, rst       - clock, async active-high reset
//                clr            - synchronous clear of every row
//                wr_en/wr_row/wr_data - write port
//                rd_row/rd_data - async read port (out-of-range rows read 0)
//                boardFlat      - row r at bits [r*WIDTH +: WIDTH]
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_board #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int ROW_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [ROW_W-1:0]        wr_row,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [ROW_W-1:0]        rd_row,
    output logic [WIDTH-1:0]        rd_data,
    output logic [WIDTH*HEIGHT-1:0] boardFlat
);

    logic [WIDTH-1:0] r_rows [HEIGHT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < HEIGHT; r++) begin
                r_rows[r] <= '0;
            end
        end else begin
            for (int r = 0; r < HEIGHT; r++) begin
                if (clr) begin
                    r_rows[r] <= '0;
                end else if (wr_en && (wr_row == ROW_W'(r))) begin
                    r_rows[r] <= wr_data;
                end
            end
        end
    end

    // Decoded mux so an index past the last row (level 0 gives row -1,
    // which wraps) simply reads as an empty row.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < HEIGHT; r++) begin
            if (rd_row == ROW_W'(r)) begin
                rd_data = r_rows[r];
            end
        end
    end

    generate
        for (genvar g = 0; g < HEIGHT; g++) begin : g_flat
            assign boardFlat[g*WIDTH +: WIDTH] = r_rows[g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/stack_evaluator.sv
// ============================================================================
//  Module      : stack_evaluator
//  Description : Captures the halted sliding row on a stop-button rising
//                edge, intersects it with the row beneath, commits the
//                overlap to the board, advances the level and hands the
//                trimmed row back as the next seed. Flags sticky win/loss.
//  Ports       : clk, rst   - clock, async active-high reset
//                stopBtn    - debounced stop level (edge detected here)
//                restart    - one-cycle new-game request (highest priority)
//                blockLoc   - current row position from the shifter
//                nextBlock  - seed row for the shifter's next load
//                loadNext   - one-cycle reload strobe for the shifter
//                level      - number of committed rows, 0..HEIGHT
//                boardFlat  - board image, row r at [r*WIDTH +: WIDTH]
//                busy       - evaluation in progress
//                gameOver   - sticky loss flag
//                gameWon    - sticky win flag
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_evaluator
    import stacker_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter int               HEIGHT     = DEF_HEIGHT,
    parameter logic [WIDTH-1:0] INIT_BLOCK = DEF_INIT_BLOCK
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stopBtn,
    input  logic                         restart,
    input  logic [WIDTH-1:0]             blockLoc,
    output logic [WIDTH-1:0]             nextBlock,
    output logic                         loadNext,
    output logic [$clog2(HEIGHT+1)-1:0]  level,
    output logic [WIDTH*HEIGHT-1:0]      boardFlat,
    output logic                         busy,
    output logic                         gameOver,
    output logic                         gameWon
);

    localparam int c_LVL_W = $clog2(HEIGHT + 1);

    state_t              r_state;
    state_t              w_nextState;
    logic                r_stopPrev;
    logic                w_stopRise;
    logic [WIDTH-1:0]    r_placed;
    logic [WIDTH-1:0]    r_overlap;
    logic [c_LVL_W-1:0]  r_level;
    logic [WIDTH-1:0]    r_nextBlock;
    logic                r_loadNext;
    logic                r_gameOver;
    logic                r_gameWon;
    logic                w_boardWr;
    logic                w_boardClr;
    logic                w_lastRow;
    logic [c_LVL_W-1:0]  w_rdRow;
    logic [WIDTH-1:0]    w_rdData;

    assign w_stopRise = stopBtn & ~r_stopPrev;
    assign w_lastRow  = (r_level == c_LVL_W'(HEIGHT - 1));
    assign w_rdRow    = r_level - c_LVL_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stopPrev <= 1'b0;
        end else begin
            r_stopPrev <= stopBtn;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and board-control decode; restart overrides everything,
    // which also suppresses a commit that would land on the same edge.
    always_comb begin
        w_nextState = r_state;
        w_boardWr   = 1'b0;
        w_boardClr  = 1'b0;
        if (restart) begin
            w_nextState = S_IDLE;
            w_boardClr  = 1'b1;
        end else begin
            case (r_state)
                S_IDLE:   if (w_stopRise) w_nextState = S_CAPT;
                S_CAPT:   w_nextState = S_EVAL;
                S_EVAL:   w_nextState = (r_overlap == '0) ? S_LOSE : S_COMMIT;
                S_COMMIT: begin
                    w_boardWr   = 1'b1;
                    w_nextState = w_lastRow ? S_WIN : S_IDLE;
                end
                S_WIN:    w_nextState = S_WIN;
                S_LOSE:   w_nextState = S_LOSE;
                default:  w_nextState = S_IDLE;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_placed    <= '0;
            r_overlap   <= '0;
            r_level     <= '0;
            r_nextBlock <= INIT_BLOCK;
            r_loadNext  <= 1'b0;
            r_gameOver  <= 1'b0;
            r_gameWon   <= 1'b0;
        end else begin
            r_loadNext <= 1'b0;
            if (restart) begin
                r_level     <= '0;
                r_nextBlock <= INIT_BLOCK;
                r_loadNext  <= 1'b1;
                r_gameOver  <= 1'b0;
                r_gameWon   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_stopRise) r_placed <= blockLoc;
                    end
                    S_CAPT: begin
                        // The first row has nothing beneath it and is kept whole.
                        r_overlap <= (r_level == '0) ? r_placed : (r_placed & w_rdData);
                    end
                    S_EVAL: begin
                        if (r_overlap == '0) r_gameOver <= 1'b1;
                    end
                    S_COMMIT: begin
                        r_level     <= r_level + c_LVL_W'(1);
                        r_nextBlock <= r_overlap;
                        if (w_lastRow) begin
                            r_gameWon <= 1'b1;
                        end else begin
                            r_loadNext <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    stack_board #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ROW_W  (c_LVL_W)
    ) u_board (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_boardClr),
        .wr_en     (w_boardWr),
        .wr_row    (r_level),
        .wr_data   (r_overlap),
        .rd_row    (w_rdRow),
        .rd_data   (w_rdData),
        .boardFlat (boardFlat)
    );

    assign nextBlock = r_nextBlock;
    assign loadNext  = r_loadNext;
    assign level     = r_level;
    assign busy      = (r_state == S_CAPT) || (r_state == S_EVAL) || (r_state == S_COMMIT);
    assign gameOver  = r_gameOver;
    assign gameWon   = r_gameWon;

endmodule

`default_nettype wire
